// File: rtl/ysyx_23060332_idu_pipe_pkg.sv
// rtl/ysyx_23060332_idu_pipe_pkg.sv - opcode/funct constants and operand-select enums for the IDU
package ysyx_23060332_idu_pipe_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] INST_FENCE    = 7'b0001111;

  // funct3 values that gate legality
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_SD      = 3'b011;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Fully fixed system encodings
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Widest datapath zero; slice to XLEN at use
  localparam logic [63:0] ZERO_WORD = 64'h0;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_IMMU} op1_sel_e;
  typedef enum logic [2:0] {OP2_ZERO, OP2_RS2, OP2_IMMI, OP2_IMMS, OP2_IMMU, OP2_FOUR} op2_sel_e;
  typedef enum logic [1:0] {JMP_NONE, JMP_PC_B, JMP_PC_J, JMP_RS1_I} jmp_sel_e;

  // Bundle: op1, op2, op1_jump, op2_jump, rdata1, rdata2, reg_wen, waddr, inst, trap, illegal
  function automatic int idu_bundle_width(input int xlen);
    return 6 * xlen + 1 + 5 + 32 + 1 + 1;
  endfunction

endpackage

// File: rtl/ysyx_23060332_imm_gen.sv
// rtl/ysyx_23060332_imm_gen.sv - RV immediate extraction, every form sign-extended to XLEN
module ysyx_23060332_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  // opcode bits carry no immediate information
  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  // All five formats share inst[31] as the sign bit
  always_comb begin
    imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    imm_u = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
    imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  end

endmodule

// File: rtl/ysyx_23060332_idu_pipe.sv
// rtl/ysyx_23060332_idu_pipe.sv - pipelined RV32I/RV64I decode stage with 2-entry skid buffer
module ysyx_23060332_idu_pipe
  import ysyx_23060332_idu_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] reg_rdata1,
  input  logic [XLEN-1:0] reg_rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op1_jump,
  output logic [XLEN-1:0] op2_jump,
  output logic [XLEN-1:0] reg_rdata1_o,
  output logic [XLEN-1:0] reg_rdata2_o,
  output logic            reg_wen,
  output logic [4:0]      waddr,
  output logic [31:0]     inst_o,
  output logic            trap,
  output logic            illegal
);

  localparam int BUNDLE_W = idu_bundle_width(XLEN);
  localparam bit IS_RV64  = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op1_jump;
    logic [XLEN-1:0] op2_jump;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            reg_wen;
    logic [4:0]      waddr;
    logic [31:0]     inst;
    logic            trap;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode, funct7, shf7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign rd     = inst_i[11:7];
  // RV64 shift amounts are 6 bits wide, so inst[25] belongs to shamt there
  assign shf7   = IS_RV64 ? {inst_i[31:26], 1'b0} : inst_i[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  ysyx_23060332_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst_i),
    .imm_i  (imm_i),
    .imm_s  (imm_s),
    .imm_b  (imm_b),
    .imm_u  (imm_u),
    .imm_j  (imm_j)
  );

  logic     legal, wr, use_rs1, use_rs2, is_trap;
  op1_sel_e op1_sel;
  op2_sel_e op2_sel;
  jmp_sel_e jmp_sel;

  // Classify the instruction from its encoding alone (independent of regfile data)
  always_comb begin
    legal   = 1'b0;
    wr      = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_trap = 1'b0;
    op1_sel = OP1_ZERO;
    op2_sel = OP2_ZERO;
    jmp_sel = JMP_NONE;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL)     legal = (shf7 == F7_BASE);
        else if (funct3 == F3_SR) legal = (shf7 == F7_BASE) || (shf7 == F7_ALT);
        else                      legal = 1'b1;
        wr = 1'b1; use_rs1 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_IMMI;
      end
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_RS2;
      end
      OPC_LOAD: begin
        case (funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
          F3_LD, F3_LWU:                       legal = IS_RV64;
          default:                             legal = 1'b0;
        endcase
        wr = 1'b1; use_rs1 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_IMMI;
      end
      OPC_STORE: begin
        case (funct3)
          F3_SB, F3_SH, F3_SW: legal = 1'b1;
          F3_SD:               legal = IS_RV64;
          default:             legal = 1'b0;
        endcase
        use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_IMMS;
      end
      OPC_BRANCH: begin
        legal = (funct3 != F3_BR_RSV0) && (funct3 != F3_BR_RSV1);
        use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_RS2; jmp_sel = JMP_PC_B;
      end
      OPC_LUI: begin
        legal = 1'b1; wr = 1'b1; op1_sel = OP1_IMMU; op2_sel = OP2_ZERO;
      end
      OPC_AUIPC: begin
        legal = 1'b1; wr = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_IMMU;
      end
      OPC_JAL: begin
        legal = 1'b1; wr = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_FOUR; jmp_sel = JMP_PC_J;
      end
      OPC_JALR: begin
        legal = (funct3 == F3_ADD);
        wr = 1'b1; use_rs1 = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_FOUR; jmp_sel = JMP_RS1_I;
      end
      INST_FENCE: legal = (funct3 == F3_ADD);
      OPC_SYSTEM: begin
        if (inst_i == INST_ECALL) begin
          legal = 1'b1;
        end else if (inst_i == INST_EBREAK) begin
          legal   = 1'b1;
          is_trap = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        legal = IS_RV64 && ((funct3 == F3_ADD) ||
                            ((funct3 == F3_SLL) && (funct7 == F7_BASE)) ||
                            ((funct3 == F3_SR) && ((funct7 == F7_BASE) || (funct7 == F7_ALT))));
        wr = 1'b1; use_rs1 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_IMMI;
      end
      OPC_OP_32: begin
        legal = IS_RV64 && ((((funct3 == F3_ADD) || (funct3 == F3_SR)) &&
                             ((funct7 == F7_BASE) || (funct7 == F7_ALT))) ||
                            ((funct3 == F3_SLL) && (funct7 == F7_BASE)));
        wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = OP1_RS1; op2_sel = OP2_RS2;
      end
      default: legal = 1'b0;
    endcase
    if (inst_i[1:0] != 2'b11) legal = 1'b0;
  end

  assign raddr1 = (legal && use_rs1) ? rs1 : 5'd0;
  assign raddr2 = (legal && use_rs2) ? rs2 : 5'd0;

  bundle_t dec;

  // Build the bundle; an illegal encoding carries only inst and the illegal flag
  always_comb begin
    dec      = '0;
    dec.inst = inst_i;
    if (!legal) begin
      dec.illegal = 1'b1;
    end else begin
      case (op1_sel)
        OP1_RS1:  dec.op1 = reg_rdata1;
        OP1_PC:   dec.op1 = inst_addr;
        OP1_IMMU: dec.op1 = imm_u;
        default:  dec.op1 = ZERO_WORD[XLEN-1:0];
      endcase
      case (op2_sel)
        OP2_RS2:  dec.op2 = reg_rdata2;
        OP2_IMMI: dec.op2 = imm_i;
        OP2_IMMS: dec.op2 = imm_s;
        OP2_IMMU: dec.op2 = imm_u;
        OP2_FOUR: dec.op2 = XLEN'(4);
        default:  dec.op2 = ZERO_WORD[XLEN-1:0];
      endcase
      case (jmp_sel)
        JMP_PC_B:  begin dec.op1_jump = inst_addr;  dec.op2_jump = imm_b; end
        JMP_PC_J:  begin dec.op1_jump = inst_addr;  dec.op2_jump = imm_j; end
        JMP_RS1_I: begin dec.op1_jump = reg_rdata1; dec.op2_jump = imm_i; end
        default:   begin dec.op1_jump = ZERO_WORD[XLEN-1:0]; dec.op2_jump = ZERO_WORD[XLEN-1:0]; end
      endcase
      dec.rdata1  = use_rs1 ? reg_rdata1 : ZERO_WORD[XLEN-1:0];
      dec.rdata2  = use_rs2 ? reg_rdata2 : ZERO_WORD[XLEN-1:0];
      dec.reg_wen = wr && (rd != 5'd0);
      dec.waddr   = wr ? rd : 5'd0;
      dec.trap    = is_trap;
    end
  end

  logic [BUNDLE_W-1:0] main_q, main_d, skid_q, skid_d;
  logic                main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic                accept;

  // Without the skid entry the stage only accepts when the main entry drains this cycle
  assign in_ready = !rst && (SKID_EN ? !skid_valid_q : (!main_valid_q || out_ready));
  assign accept   = in_valid && in_ready;

  // Buffer next state: flush wins, then fill/pop; skid only catches input while main is held
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  bundle_t out_b;
  assign out_b        = bundle_t'(main_q);
  assign out_valid    = main_valid_q;
  assign op1          = out_b.op1;
  assign op2          = out_b.op2;
  assign op1_jump     = out_b.op1_jump;
  assign op2_jump     = out_b.op2_jump;
  assign reg_rdata1_o = out_b.rdata1;
  assign reg_rdata2_o = out_b.rdata2;
  assign reg_wen      = out_b.reg_wen;
  assign waddr        = out_b.waddr;
  assign inst_o       = out_b.inst;
  assign trap         = out_b.trap;
  assign illegal      = out_b.illegal;

endmodule

// File: tb/tb_ysyx_23060332_idu_pipe.sv
// tb/tb_ysyx_23060332_idu_pipe.sv - vector table plus scoreboard bench for the IDU pipe stage
module tb_ysyx_23060332_idu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst_i, inst_addr, reg_rdata1, reg_rdata2;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] op1, op2, op1_jump, op2_jump, reg_rdata1_o, reg_rdata2_o, inst_o;
  logic        reg_wen, trap, illegal;

  always #5 clk = ~clk;

  // Register file model: x[n] = n * 16
  assign reg_rdata1 = {23'd0, raddr1, 4'd0};
  assign reg_rdata2 = {23'd0, raddr2, 4'd0};

  ysyx_23060332_idu_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .inst_addr(inst_addr), .raddr1(raddr1), .raddr2(raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .out_valid(out_valid),
    .out_ready(out_ready), .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
    .reg_rdata1_o(reg_rdata1_o), .reg_rdata2_o(reg_rdata2_o), .reg_wen(reg_wen),
    .waddr(waddr), .inst_o(inst_o), .trap(trap), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] inst, pc;
    logic [4:0]  ra1, ra2;
    logic [31:0] op1, op2, j1, j2, r1, r2;
    logic        wen;
    logic [4:0]  waddr;
    logic        trap, ill;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] inst, pc, input logic [4:0] ra1, ra2,
                              input logic [31:0] o1, o2, j1, j2, r1, r2,
                              input logic wen, input logic [4:0] wa, input logic trp, ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.ra1 = ra1; v.ra2 = ra2;
    v.op1 = o1; v.op2 = o2; v.j1 = j1; v.j2 = j2; v.r1 = r1; v.r2 = r2;
    v.wen = wen; v.waddr = wa; v.trap = trp; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_bundle(input vec_t e);
    chk("op1", op1, e.op1);
    chk("op2", op2, e.op2);
    chk("op1_jump", op1_jump, e.j1);
    chk("op2_jump", op2_jump, e.j2);
    chk("reg_rdata1_o", reg_rdata1_o, e.r1);
    chk("reg_rdata2_o", reg_rdata2_o, e.r2);
    chk("reg_wen", reg_wen, e.wen);
    chk("waddr", waddr, e.waddr);
    chk("inst_o", inst_o, e.inst);
    chk("trap", trap, e.trap);
    chk("illegal", illegal, e.ill);
  endtask

  // One cycle: drive at negedge, sample 1ns later, update scoreboard
  task automatic step(input logic v, input vec_t t, input logic ordy, input logic fl,
                      output logic acc);
    @(negedge clk);
    in_valid  = v;
    inst_i    = t.inst;
    inst_addr = t.pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = v && in_ready && !fl;
    if (v) begin
      chk("raddr1", raddr1, t.ra1);
      chk("raddr2", raddr2, t.ra2);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_bundle", 1, 0);
        else cmp_bundle(sb.pop_front());
      end
      if (acc) sb.push_back(t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   tries;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst_i = 32'h0; inst_addr = 32'h0;

    //        inst          pc            ra1 ra2 op1           op2           j1            j2            r1     r2     wen wa trap ill
    vecs.push_back(mk(32'hFFF08293, 32'h80000000, 1, 0, 32'h10,       32'hFFFFFFFF, 0,            0,            32'h10, 0,     1, 5, 0, 0)); // ADDI x5,x1,-1
    vecs.push_back(mk(32'hFE000CE3, 32'h80000010, 0, 0, 0,            0,            32'h80000010, 32'hFFFFFFF8, 0,      0,     0, 0, 0, 0)); // BEQ x0,x0,-8
    vecs.push_back(mk(32'hFFFFFFFF, 32'h80000014, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // all ones
    vecs.push_back(mk(32'h00100073, 32'h80000018, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 1, 0)); // EBREAK
    vecs.push_back(mk(32'h00100013, 32'h8000001C, 0, 0, 0,            1,            0,            0,            0,      0,     0, 0, 0, 0)); // ADDI x0,x0,1
    vecs.push_back(mk(32'h002081B3, 32'h80000020, 1, 2, 32'h10,       32'h20,       0,            0,            32'h10, 32'h20,1, 3, 0, 0)); // ADD x3,x1,x2
    vecs.push_back(mk(32'h40218233, 32'h80000024, 3, 2, 32'h30,       32'h20,       0,            0,            32'h30, 32'h20,1, 4, 0, 0)); // SUB x4,x3,x2
    vecs.push_back(mk(32'h40209233, 32'h80000028, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // SLL with funct7 0x20
    vecs.push_back(mk(32'h123453B7, 32'h8000002C, 0, 0, 32'h12345000, 0,            0,            0,            0,      0,     1, 7, 0, 0)); // LUI x7
    vecs.push_back(mk(32'hFFFFF417, 32'h80000100, 0, 0, 32'h80000100, 32'hFFFFF000, 0,            0,            0,      0,     1, 8, 0, 0)); // AUIPC x8
    vecs.push_back(mk(32'h010000EF, 32'h80000200, 0, 0, 32'h80000200, 4,            32'h80000200, 32'h10,       0,      0,     1, 1, 0, 0)); // JAL x1,+16
    vecs.push_back(mk(32'h008100E7, 32'h80000300, 2, 0, 32'h80000300, 4,            32'h20,       8,            32'h20, 0,     1, 1, 0, 0)); // JALR x1,8(x2)
    vecs.push_back(mk(32'hFE312E23, 32'h80000304, 2, 3, 32'h20,       32'hFFFFFFFC, 0,            0,            32'h20, 32'h30,0, 0, 0, 0)); // SW x3,-4(x2)
    vecs.push_back(mk(32'h0040A303, 32'h80000308, 1, 0, 32'h10,       4,            0,            0,            32'h10, 0,     1, 6, 0, 0)); // LW x6,4(x1)
    vecs.push_back(mk(32'h0040B303, 32'h8000030C, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // LD on RV32
    vecs.push_back(mk(32'h4030D293, 32'h80000310, 1, 0, 32'h10,       32'h403,      0,            0,            32'h10, 0,     1, 5, 0, 0)); // SRAI x5,x1,3
    vecs.push_back(mk(32'h40309293, 32'h80000314, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // SLLI with funct7 0x20
    vecs.push_back(mk(32'h00000073, 32'h80000318, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 0)); // ECALL
    vecs.push_back(mk(32'h0FF0000F, 32'h8000031C, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 0)); // FENCE
    vecs.push_back(mk(32'h00100011, 32'h80000320, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // inst[1:0]!=11
    vecs.push_back(mk(32'h00002063, 32'h80000324, 0, 0, 0,            0,            0,            0,            0,      0,     0, 0, 0, 1)); // branch funct3 010

    // Reset held 3 cycles with in_valid high
    for (int c = 0; c < 3; c++) begin
      step(1'b1, vecs[0], 1'b1, 1'b0, acc);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs_zero", |{op1, op2, op1_jump, op2_jump, reg_rdata1_o, reg_rdata2_o,
                                reg_wen, waddr, inst_o, trap, illegal}, 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table: one instruction per cycle, full throughput
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, vecs[i], 1'b1, 1'b0, acc);
      chk("table_accept", acc, 1);
    end
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    chk("table_drained", sb.size(), 0);

    // Backpressure: three back-to-back ops with out_ready low
    step(1'b1, vecs[0], 1'b0, 1'b0, acc);
    chk("bp_accept1", acc, 1);
    step(1'b1, vecs[5], 1'b0, 1'b0, acc);
    chk("bp_accept2", acc, 1);
    step(1'b1, vecs[8], 1'b0, 1'b0, acc);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_held_op1", op1, vecs[0].op1);
    step(1'b1, vecs[8], 1'b0, 1'b0, acc);
    chk("bp_held_waddr", waddr, vecs[0].waddr);
    tries = 0;
    do begin
      step(1'b1, vecs[8], 1'b1, 1'b0, acc);
      tries++;
    end while (!acc && tries < 10);
    chk("bp_third_accepted", acc, 1);
    tries = 0;
    while (sb.size() != 0 && tries < 10) begin
      step(1'b0, vecs[0], 1'b1, 1'b0, acc);
      tries++;
    end
    chk("bp_drained", sb.size(), 0);
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    chk("bp_idle_out_valid", out_valid, 0);

    // Flush with both entries full and a same-cycle input
    step(1'b1, vecs[0], 1'b0, 1'b0, acc);
    step(1'b1, vecs[5], 1'b0, 1'b0, acc);
    step(1'b1, vecs[8], 1'b0, 1'b1, acc);
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    step(1'b1, vecs[12], 1'b1, 1'b0, acc);
    chk("post_flush_accept", acc, 1);
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    chk("post_flush_latency", out_valid, 1);
    step(1'b0, vecs[0], 1'b1, 1'b0, acc);
    chk("post_flush_empty", out_valid, 0);
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
